icu_sequencer: RTL and testbench

ICU_SEQUENCER -- requirements
Module: icu_sequencer

---
 rtl/icu_sequencer.sv | 112 +++++++++++
 tb/tb_icu_sequencer.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/icu_sequencer.sv
// icu_sequencer: 4-cycle fetch/latch/exec/resolve instruction sequencer with return stack (ICU_SEQ_STACK_EN selects a LIFO, otherwise one return register)
module icu_sequencer #(
  parameter int ADDR_W      = 8,
  parameter int STACK_DEPTH = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              run,
  input  logic              resume,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [7:0]        rom_data,
  output logic [3:0]        instruction,
  output logic [3:0]        io_addr,
  input  logic              jmp,
  input  logic              rtn,
  input  logic              flgf,
  input  logic              result,
  output logic              busy,
  output logic              halted,
  output logic              stack_err
);
`ifdef ICU_SEQ_STACK_EN
  localparam int DEPTH = STACK_DEPTH;
`else
  localparam int DEPTH = (STACK_DEPTH > 0) ? 1 : 1;
`endif
  localparam int SP_W = $clog2(DEPTH + 1);
  localparam int IX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [3:0] SKZ = 4'b1110;
  typedef enum logic [2:0] {IDLE, FETCH, LATCH, EXEC, RESOLVE, HALT} state_t;
  state_t            state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [3:0]        op_q, io_q;
  logic [ADDR_W-1:0] stk_q [DEPTH];
  logic [SP_W-1:0]   sp_q, sp_d;
  logic              err_q, err_d, push, full, empty, skz;
  logic [IX_W-1:0]   wr_idx, top_idx;
  assign full        = sp_q == SP_W'(DEPTH);
  assign empty       = sp_q == '0;
  assign skz         = op_q == SKZ;
  assign top_idx     = IX_W'(sp_q - 1'b1);
  assign rom_addr    = pc_q;
  assign instruction = (state_q == EXEC) ? op_q : 4'b0000;
  assign io_addr     = io_q;
  assign busy        = state_q inside {FETCH, LATCH, EXEC, RESOLVE};
  assign halted      = state_q == HALT;
  assign stack_err   = err_q;
  // state register
  always_ff @(posedge clk) begin
    state_q <= reset ? IDLE : state_d;
  end
  // next-state: flgf halts only when no higher-priority branch claimed RESOLVE
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    state_d = run ? FETCH : IDLE;
      FETCH:   state_d = LATCH;
      LATCH:   state_d = EXEC;
      EXEC:    state_d = RESOLVE;
      RESOLVE: state_d = (!jmp && !rtn && !skz && flgf) ? HALT : (run ? FETCH : IDLE);
      HALT:    state_d = resume ? (run ? FETCH : IDLE) : HALT;
      default: state_d = IDLE;
    endcase
  end
  // next pc and stack bookkeeping, priority jmp > rtn > SKZ > flgf/default
  always_comb begin
    pc_d   = pc_q;
    sp_d   = sp_q;
    err_d  = err_q;
    push   = 1'b0;
    wr_idx = IX_W'(sp_q);
    if (state_q == RESOLVE) begin
      if (jmp) begin
        pc_d = {io_q, {(ADDR_W-4){1'b0}}};
`ifdef ICU_SEQ_STACK_EN
        push  = !full;
        sp_d  = full ? sp_q : sp_q + 1'b1;
        err_d = err_q | full;
`else
        push   = 1'b1;
        wr_idx = '0;
        sp_d   = SP_W'(1);
`endif
      end else if (rtn) begin
        pc_d  = empty ? '0 : stk_q[top_idx];
        sp_d  = empty ? sp_q : sp_q - 1'b1;
        err_d = err_q | empty;
      end else begin
        pc_d = (skz && result) ? pc_q + ADDR_W'(2) : pc_q + 1'b1;
      end
    end
  end
  // pc, stack pointer, error flag and latched instruction word
  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q  <= '0;
      sp_q  <= '0;
      err_q <= 1'b0;
      op_q  <= '0;
      io_q  <= '0;
    end else begin
      pc_q  <= pc_d;
      sp_q  <= sp_d;
      err_q <= err_d;
      if (state_q == LATCH) {op_q, io_q} <= rom_data;
    end
  end
  // return-address storage; emptiness is tracked by sp_q alone
  always_ff @(posedge clk) begin
    if (!reset && push) stk_q[wr_idx] <= pc_q + 1'b1;
  end
endmodule

// File: tb/tb_icu_sequencer.sv
// tb_icu_sequencer: randomized and directed checks of icu_sequencer against a queue-based program-flow model
module tb_icu_sequencer;
`ifdef ICU_SEQ_STACK_EN
  localparam int MD = 4;
`else
  localparam int MD = 1;
`endif
  logic clk = 1'b0;
  logic reset, run, resume, jmp, rtn, flgf, result;
  logic [7:0] rom_addr, rom_data;
  logic [3:0] instruction, io_addr;
  logic busy, halted, stack_err;
  logic [7:0] rom [256];
  logic [7:0] mpc;
  logic [7:0] mstk [$];
  bit merr, mhalt;
  int checks = 0, passes = 0;

  icu_sequencer #(.ADDR_W(8), .STACK_DEPTH(4)) dut (
    .clk(clk), .reset(reset), .run(run), .resume(resume), .rom_addr(rom_addr),
    .rom_data(rom_data), .instruction(instruction), .io_addr(io_addr), .jmp(jmp),
    .rtn(rtn), .flgf(flgf), .result(result), .busy(busy), .halted(halted), .stack_err(stack_err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) rom_data <= rom[rom_addr];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic fill(input logic [7:0] v);
    for (int i = 0; i < 256; i++) rom[i] = v;
  endtask

  task automatic do_reset();
    reset = 1; run = 0; resume = 0; jmp = 0; rtn = 0; flgf = 0; result = 0;
    step();
    reset = 0;
    mpc = 0; mstk.delete(); merr = 0; mhalt = 0;
    checks++; if (rom_addr !== 8'h00) $display("FAIL rst_rom_addr: got %h want 00", rom_addr); else passes++;
    checks++; if (instruction !== 4'h0) $display("FAIL rst_instruction: got %h want 0", instruction); else passes++;
    checks++; if (io_addr !== 4'h0) $display("FAIL rst_io_addr: got %h want 0", io_addr); else passes++;
    checks++; if ({busy, halted, stack_err} !== 3'b000) $display("FAIL rst_flags: got %b want 000", {busy, halted, stack_err}); else passes++;
  endtask

  task automatic start();
    run = 1;
    step();
  endtask

  // one full instruction from FETCH; flags are held for all four cycles, only RESOLVE samples them
  task automatic do_instr(input bit jf, input bit rf, input bit ff, input bit res);
    logic [7:0] w;
    w = rom[mpc];
    jmp = jf; rtn = rf; flgf = ff; result = res;
    checks++; if (rom_addr !== mpc) $display("FAIL fetch_addr: got %h want %h", rom_addr, mpc); else passes++;
    checks++; if (busy !== 1'b1) $display("FAIL fetch_busy: got %b want 1", busy); else passes++;
    checks++; if (instruction !== 4'h0) $display("FAIL fetch_instr: got %h want 0", instruction); else passes++;
    step();
    checks++; if (instruction !== 4'h0) $display("FAIL latch_instr: got %h want 0", instruction); else passes++;
    step();
    checks++; if (instruction !== w[7:4]) $display("FAIL exec_instr: got %h want %h", instruction, w[7:4]); else passes++;
    checks++; if (io_addr !== w[3:0]) $display("FAIL exec_io: got %h want %h", io_addr, w[3:0]); else passes++;
    step();
    checks++; if (instruction !== 4'h0) $display("FAIL resolve_instr: got %h want 0", instruction); else passes++;
    checks++; if (io_addr !== w[3:0]) $display("FAIL resolve_io: got %h want %h", io_addr, w[3:0]); else passes++;
    step();
    jmp = 0; rtn = 0; flgf = 0; result = 0;
    if (jf) begin
      if (mstk.size() < MD) mstk.push_back(mpc + 8'd1);
      else if (MD > 1) merr = 1;
      else mstk[0] = mpc + 8'd1;
      mpc = {w[3:0], 4'h0};
    end else if (rf) begin
      if (mstk.size() == 0) begin mpc = 0; merr = 1; end
      else mpc = mstk.pop_back();
    end else begin
      mpc = (w[7:4] == 4'hE && res) ? mpc + 8'd2 : mpc + 8'd1;
      mhalt = (w[7:4] != 4'hE) && ff;
    end
    checks++; if (rom_addr !== mpc) $display("FAIL next_pc: got %h want %h", rom_addr, mpc); else passes++;
    checks++; if (stack_err !== merr) $display("FAIL stack_err: got %b want %b", stack_err, merr); else passes++;
    checks++; if (halted !== mhalt) $display("FAIL halted: got %b want %b", halted, mhalt); else passes++;
    checks++; if (busy !== (!mhalt && run)) $display("FAIL post_busy: got %b want %b", busy, !mhalt && run); else passes++;
  endtask

  task automatic test_reset();
    fill(8'h10);
    do_reset();
    repeat (3) step();
    checks++; if ({busy, rom_addr} !== 9'h0) $display("FAIL idle_hold: got %h want 000", {busy, rom_addr}); else passes++;
  endtask

  task automatic test_sequential();
    do_reset(); fill(8'h10); start();
    repeat (8) do_instr(0, 0, 0, 0);
    checks++; if (rom_addr !== 8'h08) $display("FAIL seq_end: got %h want 08", rom_addr); else passes++;
  endtask

  task automatic test_jump_return();
    do_reset(); fill(8'h10); rom[3] = 8'hC2; start();
    repeat (3) do_instr(0, 0, 0, 0);
    do_instr(1, 0, 0, 0);
    checks++; if (rom_addr !== 8'h20) $display("FAIL jmp_target: got %h want 20", rom_addr); else passes++;
    do_instr(0, 1, 0, 0);
    checks++; if (rom_addr !== 8'h04) $display("FAIL rtn_target: got %h want 04", rom_addr); else passes++;
  endtask

  task automatic test_skz();
    for (int r = 1; r >= 0; r--) begin
      do_reset(); fill(8'h10); rom[5] = 8'hE0; start();
      repeat (5) do_instr(0, 0, 0, 0);
      do_instr(0, 0, 1, r[0]);
      checks++; if (rom_addr !== (r[0] ? 8'h07 : 8'h06)) $display("FAIL skz_%0d: got %h", r, rom_addr); else passes++;
    end
    do_reset(); fill(8'h10); rom[0] = 8'h1F; rom[8'hFF] = 8'hE0; start();
    do_instr(1, 0, 0, 0);
    repeat (15) do_instr(0, 0, 0, 0);
    do_instr(0, 0, 0, 1);
    checks++; if (rom_addr !== 8'h01) $display("FAIL skz_wrap: got %h want 01", rom_addr); else passes++;
  endtask

  task automatic test_halt();
    do_reset(); fill(8'h10); start();
    repeat (9) do_instr(0, 0, 0, 0);
    do_instr(0, 0, 1, 0);
    repeat (3) step();
    checks++; if ({halted, busy, rom_addr} !== {2'b10, 8'h0A}) $display("FAIL halt_hold: got %b%b %h want 10 0a", halted, busy, rom_addr); else passes++;
    resume = 1; step(); resume = 0; mhalt = 0;
    do_instr(0, 0, 0, 0);
  endtask

  task automatic test_stack();
    do_reset(); fill(8'h10); start();
    for (int i = 0; i <= MD; i++) begin
      rom[i * 16] = {4'h1, 4'(i + 1)};
      do_instr(1, 0, 0, 0);
    end
    checks++; if (rom_addr !== 8'((MD + 1) * 16)) $display("FAIL deep_jmp: got %h want %h", rom_addr, 8'((MD + 1) * 16)); else passes++;
    do_instr(1, 1, 0, 0);
    repeat (MD + 1) do_instr(0, 1, 0, 0);
    checks++; if ({stack_err, rom_addr} !== 9'h100) $display("FAIL underflow: got %b %h want 1 00", stack_err, rom_addr); else passes++;
  endtask

  task automatic test_reset_mid();
    do_reset(); fill(8'h10); rom[0] = 8'h13; start();
    do_instr(1, 0, 0, 0);
    step(); step();
    reset = 1; step(); reset = 0;
    mpc = 0; mstk.delete(); merr = 0;
    checks++; if ({busy, halted, stack_err, instruction, io_addr, rom_addr} !== 19'h0) $display("FAIL mid_reset: got %h want 0", {busy, halted, stack_err, instruction, io_addr, rom_addr}); else passes++;
    start();
    do_instr(0, 1, 0, 0);
  endtask

  task automatic test_run_drop();
    do_reset(); fill(8'h10); start();
    run = 0;
    do_instr(0, 0, 0, 0);
    repeat (3) step();
    checks++; if ({busy, rom_addr} !== 9'h001) $display("FAIL run_drop: got %h want 001", {busy, rom_addr}); else passes++;
    run = 1; step();
    do_instr(0, 0, 0, 0);
  endtask

  task automatic test_random();
    do_reset();
    for (int i = 0; i < 256; i++) rom[i] = 8'($urandom);
    start();
    for (int n = 0; n < 300; n++) begin
      do_instr($urandom_range(0, 4) == 0, $urandom_range(0, 4) == 0, $urandom_range(0, 9) == 0, 1'($urandom));
      if (mhalt) begin
        repeat ($urandom_range(0, 2)) step();
        resume = 1; step(); resume = 0; mhalt = 0;
      end
    end
  endtask

  initial begin
    test_reset();
    test_sequential();
    test_jump_return();
    test_skz();
    test_halt();
    test_stack();
    test_reset_mid();
    test_run_drop();
    test_random();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
